uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with message-granular
// round-robin arbitration, a hold timeout for stalled senders and a tx_busy watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int BUSY_WAIT    = 16
) (
  input  logic                 brd_clk,
  input  logic                 brd_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [1:0]           grant_id,
  output logic                 err_timeout
);

  localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
  localparam int BUSY_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_HI, WAIT_LO} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        grant_id_d;
  logic              grant_active_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              last_q, last_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [1:0]        pick_id, scan_id, next_ptr;
  logic              pick_found;
  logic              frame_done, release_grant;
  logic [7:0]        granted_byte;

  // Circular search for the first valid requester starting at rr_ptr.
  always_comb begin
    pick_id    = rr_ptr_q;
    pick_found = 1'b0;
    scan_id    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_id = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_id]) begin
        pick_id    = scan_id;
        pick_found = 1'b1;
      end
    end
  end

  assign next_ptr     = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
  assign granted_byte = req_data[{grant_id, 3'b000} +: 8];
  assign tx_data      = tx_data_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id;
    grant_active_d = grant_active;
    hold_cnt_d     = hold_cnt_q;
    busy_cnt_d     = busy_cnt_q;
    last_d         = last_q;
    tx_data_d      = tx_data_q;
    req_ready      = '0;
    tx_start       = 1'b0;
    err_timeout    = 1'b0;
    frame_done     = 1'b0;
    release_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_id_d     = pick_id;
          grant_active_d = 1'b1;
          hold_cnt_d     = '0;
          state_d        = LOCKED;
        end
      end
      LOCKED: begin
        if (req_valid[grant_id]) begin
          hold_cnt_d = '0;
          if (!tx_busy) begin
            tx_start            = 1'b1;
            req_ready[grant_id] = 1'b1;
            tx_data_d           = granted_byte;
            last_d              = req_last[grant_id];
            busy_cnt_d          = '0;
            state_d             = WAIT_HI;
          end
        end else if (hold_cnt_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
          err_timeout   = 1'b1;
          release_grant = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (busy_cnt_q == BUSY_W'(BUSY_WAIT - 1)) begin
          // The core never started the frame; treat it as sent so the message can continue.
          err_timeout = 1'b1;
          frame_done  = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) frame_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (frame_done) begin
      if (last_q) begin
        release_grant = 1'b1;
      end else begin
        state_d    = LOCKED;
        hold_cnt_d = '0;
      end
    end

    if (release_grant) begin
      grant_active_d = 1'b0;
      rr_ptr_d       = next_ptr;
      state_d        = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge brd_clk or negedge brd_rst_n) begin
    if (!brd_rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      grant_id     <= 2'd0;
      grant_active <= 1'b0;
      hold_cnt_q   <= '0;
      busy_cnt_q   <= '0;
      last_q       <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id     <= grant_id_d;
      grant_active <= grant_active_d;
      hold_cnt_q   <= hold_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a UART TX core model
// with a 20-cycle busy window, and a monitor logging every tx_start and err_timeout.
module tb_uart_tx_arbiter;

  logic        clk, rst_n;
  logic [2:0]  req_valid, req_last, req_ready;
  logic [23:0] req_data;
  logic        tx_start, tx_busy, grant_active, err_timeout;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.NUM_REQ(3), .HOLD_TIMEOUT(1024), .BUSY_WAIT(16)) dut (
    .brd_clk(clk), .brd_rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_active(grant_active), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int violations = 0;
  int ready0_cnt = 0;
  logic busy_mode = 1'b1;
  logic [2:0] en = 3'b000;

  logic [8:0] rq0[$], rq1[$], rq2[$];
  logic [7:0] tx_log[$];
  int gid_log[$], ts_log[$], err_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    case (r)
      0: rq0.push_back({l, d});
      1: rq1.push_back({l, d});
      default: rq2.push_back({l, d});
    endcase
  endtask

  task automatic drive_inputs();
    req_valid[0] = en[0] && (rq0.size() > 0);
    req_data[7:0] = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
    req_last[0] = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
    req_valid[1] = en[1] && (rq1.size() > 0);
    req_data[15:8] = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
    req_last[1] = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
    req_valid[2] = en[2] && (rq2.size() > 0);
    req_data[23:16] = (rq2.size() > 0) ? rq2[0][7:0] : 8'h00;
    req_last[2] = (rq2.size() > 0) ? rq2[0][8] : 1'b0;
  endtask

  // Requesters: a byte leaves its queue only after a valid/ready handshake.
  initial begin : driver
    logic [2:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
      if (acc[2] && rq2.size() > 0) void'(rq2.pop_front());
      drive_inputs();
    end
  end

  // TX core: busy for 20 cycles starting the cycle after an accepted tx_start.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_start && busy_mode) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_log.push_back(tx_data);
        gid_log.push_back(int'(grant_id));
        ts_log.push_back(cyc);
      end
      if (err_timeout) err_log.push_back(cyc);
      if (req_ready[0]) ready0_cnt++;
      if (!$onehot0(req_ready) ||
          (req_ready != 3'b000 && (!grant_active || req_ready != (3'b001 << grant_id)))) begin
        violations++;
        $display("FAIL ready_onehot: req_ready=%b grant_id=%0d grant_active=%b", req_ready, grant_id, grant_active);
      end
      if (tx_start && tx_busy) begin
        violations++;
        $display("FAIL start_while_busy: tx_start=1 with tx_busy=1 at cycle %0d", cyc);
      end
      if (err_timeout && err_prev) begin
        violations++;
        $display("FAIL err_pulse_width: err_timeout high two cycles at cycle %0d", cyc);
      end
      err_prev = err_timeout;
    end
  end

  task automatic clear_logs();
    tx_log.delete(); gid_log.delete(); ts_log.delete(); err_log.delete();
    ready0_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 3'b000;
    busy_mode = 1'b1;
    rq0.delete(); rq1.delete(); rq2.delete();
    repeat (25) @(posedge clk);
    clear_logs();
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    total++;
    if (tx_log.size() < n) $display("FAIL %s: saw %0d tx_start, needed %0d", name, tx_log.size(), n);
    else passed++;
  endtask

  task automatic wait_err(input int n, input int budget, input string name);
    int k = 0;
    while (err_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    total++;
    if (err_log.size() < n) $display("FAIL %s: saw %0d err_timeout, needed %0d", name, err_log.size(), n);
    else passed++;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++; if (grant_active !== 1'b0) $display("FAIL %s_grant_active: got %b want 0", tag, grant_active); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL %s_grant_id: got %0d want 0", tag, grant_id); else passed++;
    total++; if (req_ready !== 3'b000) $display("FAIL %s_req_ready: got %b want 000", tag, req_ready); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL %s_tx_start: got %b want 0", tag, tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL %s_tx_data: got %h want 00", tag, tx_data); else passed++;
    total++; if (err_timeout !== 1'b0) $display("FAIL %s_err_timeout: got %b want 0", tag, err_timeout); else passed++;
  endtask

  task automatic test_reset();
    en = 3'b111;
    push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (tx_start !== 1'b0) $display("FAIL first_cycle_tx_start: got %b want 0", tx_start); else passed++;
    total++; if (grant_active !== 1'b0) $display("FAIL first_cycle_grant: got %b want 0", grant_active); else passed++;
    @(negedge clk);
    total++; if (grant_active !== 1'b1) $display("FAIL grant_next_cycle: got %b want 1", grant_active); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL grant_id_after_reset: got %0d want 0", grant_id); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_tx [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
    int exp_gid [6] = '{0, 0, 1, 1, 2, 2};
    do_reset();
    en = 3'b111;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    wait_tx(6, 400, "rr_complete");
    for (int i = 0; i < 6; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) $display("FAIL rr_byte%0d: got %h want %h", i, tx_log[i], exp_tx[i]); else passed++;
      total++; if (gid_log[i] !== exp_gid[i]) $display("FAIL rr_gid%0d: got %0d want %0d", i, gid_log[i], exp_gid[i]); else passed++;
    end
    repeat (30) @(negedge clk);
    total++; if (grant_active !== 1'b0) $display("FAIL rr_released: got %b want 0", grant_active); else passed++;
  endtask

  task automatic test_no_interleave();
    logic [7:0] exp_tx [5] = '{8'hD0, 8'hD1, 8'hD2, 8'h2E, 8'h0E};
    int exp_gid [5] = '{1, 1, 1, 2, 0};
    do_reset();
    en = 3'b111;
    push(1, 8'hD0, 1'b0); push(1, 8'hD1, 1'b0); push(1, 8'hD2, 1'b1);
    wait_tx(2, 100, "ni_byte2");
    push(0, 8'h0E, 1'b1); push(2, 8'h2E, 1'b1);
    wait_tx(4, 200, "ni_fourth");
    total++; if (ready0_cnt !== 0) $display("FAIL ni_no_ready0: got %0d ready pulses want 0", ready0_cnt); else passed++;
    wait_tx(5, 100, "ni_all");
    for (int i = 0; i < 5; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) $display("FAIL ni_byte%0d: got %h want %h", i, tx_log[i], exp_tx[i]); else passed++;
      total++; if (gid_log[i] !== exp_gid[i]) $display("FAIL ni_gid%0d: got %0d want %0d", i, gid_log[i], exp_gid[i]); else passed++;
    end
    total++; if (ready0_cnt !== 1) $display("FAIL ni_ready0_total: got %0d want 1", ready0_cnt); else passed++;
  endtask

  task automatic test_hold_timeout();
    do_reset();
    en = 3'b111;
    push(0, 8'hF0, 1'b0);
    push(1, 8'h60, 1'b1);
    wait_err(1, 1200, "hold_err");
    @(negedge clk);
    total++; if (grant_active !== 1'b0) $display("FAIL hold_release: got %b want 0", grant_active); else passed++;
    wait_tx(2, 50, "hold_next");
    total++; if (err_log[0] - ts_log[0] !== 1045) $display("FAIL hold_err_cycle: got %0d want 1045", err_log[0] - ts_log[0]); else passed++;
    total++; if (tx_log[1] !== 8'h60) $display("FAIL hold_next_byte: got %h want 60", tx_log[1]); else passed++;
    total++; if (gid_log[1] !== 1) $display("FAIL hold_next_gid: got %0d want 1", gid_log[1]); else passed++;
    total++; if (ts_log[1] - err_log[0] !== 2) $display("FAIL hold_regrant_delay: got %0d want 2", ts_log[1] - err_log[0]); else passed++;
    repeat (30) @(posedge clk);
    total++; if (err_log.size() !== 1) $display("FAIL hold_err_once: got %0d pulses want 1", err_log.size()); else passed++;
  endtask

  task automatic test_busy_timeout();
    do_reset();
    busy_mode = 1'b0;
    en = 3'b111;
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b1);
    wait_err(2, 100, "busy_err");
    repeat (5) @(posedge clk);
    total++; if (tx_log.size() !== 2) $display("FAIL busy_tx_count: got %0d want 2", tx_log.size()); else passed++;
    total++; if (tx_log[1] !== 8'h71) $display("FAIL busy_second_byte: got %h want 71", tx_log[1]); else passed++;
    total++; if (err_log[0] - ts_log[0] !== 16) $display("FAIL busy_err0_delay: got %0d want 16", err_log[0] - ts_log[0]); else passed++;
    total++; if (ts_log[1] - ts_log[0] !== 17) $display("FAIL busy_next_start: got %0d want 17", ts_log[1] - ts_log[0]); else passed++;
    total++; if (err_log[1] - ts_log[1] !== 16) $display("FAIL busy_err1_delay: got %0d want 16", err_log[1] - ts_log[1]); else passed++;
    total++; if (grant_active !== 1'b0) $display("FAIL busy_released: got %b want 0", grant_active); else passed++;
    busy_mode = 1'b1;
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    en = 3'b111;
    push(0, 8'h80, 1'b1);
    wait_tx(1, 50, "mid_first");
    push(1, 8'h90, 1'b0); push(1, 8'h91, 1'b1);
    wait_tx(2, 100, "mid_second");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    rq0.delete(); rq1.delete(); rq2.delete();
    #1 check_reset_outputs("midrst");
    clear_logs();
    push(0, 8'hAA, 1'b1); push(1, 8'hBB, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (tx_start !== 1'b0) $display("FAIL midrst_first_cycle: got %b want 0", tx_start); else passed++;
    wait_tx(2, 100, "midrst_after");
    total++; if (tx_log[0] !== 8'hAA) $display("FAIL midrst_byte0: got %h want AA", tx_log[0]); else passed++;
    total++; if (gid_log[0] !== 0) $display("FAIL midrst_rr_ptr: first grant %0d want 0", gid_log[0]); else passed++;
    total++; if (tx_log[1] !== 8'hBB) $display("FAIL midrst_byte1: got %h want BB", tx_log[1]); else passed++;
  endtask

  task automatic test_invariants();
    total++;
    if (violations !== 0) $display("FAIL invariants: got %0d violations want 0", violations);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    tx_busy = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    test_reset();
    test_round_robin();
    test_no_interleave();
    test_hold_timeout();
    test_busy_timeout();
    test_reset_mid_message();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
